// File: rtl/voice_alloc.sv
// Trigger-to-voice allocator: round-robin arbitration over edge-detected note
// requests, lowest free voice first, otherwise steal the oldest voice.
module voice_lane #(
  parameter int AGEW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            hit,
  input  logic            busy,
  output logic [AGEW-1:0] age,
  output logic            free
);
  logic [1:0] claim;

  // Claim holds the voice reserved until envseq has had time to raise busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      age   <= '0;
      claim <= '0;
    end else if (hit) begin
      age   <= '0;
      claim <= 2'd2;
    end else if (ena) begin
      if (age != {AGEW{1'b1}}) age <= age + 1'b1;
      if (claim != 2'd0) claim <= claim - 1'b1;
    end
  end

  assign free = ~busy & (claim == 2'd0);
endmodule

module voice_alloc #(
  parameter int NREQ   = 4,
  parameter int NVOICE = 4,
  parameter int AGEW   = 16,
  localparam int SW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [NREQ-1:0]      req,
  input  logic [NVOICE-1:0]    busy,
  output logic [NVOICE-1:0]    trig_out,
  output logic [NVOICE*SW-1:0] src_out,
  output logic                 steal
);
  logic [NREQ-1:0]              req_d, pending, edge_det, gmask;
  logic [SW-1:0]                ptr, gidx;
  logic                         gnt;
  logic [NVOICE-1:0]            free, hit;
  logic [NVOICE-1:0][AGEW-1:0]  age;
  logic [NVOICE-1:0][SW-1:0]    src_q;
  logic [$clog2(NVOICE+1)-1:0]  vsel, vfree, vold;
  logic                         any_free;

  assign edge_det = req & ~req_d;

  for (genvar v = 0; v < NVOICE; v++) begin : g_lane
    voice_lane #(.AGEW(AGEW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .hit  (hit[v]),
      .busy (busy[v]),
      .age  (age[v]),
      .free (free[v])
    );
  end

  // Round-robin search: walk downward so the entry nearest ptr wins.
  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (pending[(int'(ptr) + k) % NREQ]) begin
        gnt  = ena;
        gidx = SW'((int'(ptr) + k) % NREQ);
      end
    end
    gmask       = '0;
    gmask[gidx] = gnt;
  end

  always_comb begin
    any_free = |free;
    vfree    = '0;
    for (int v = NVOICE - 1; v >= 0; v--)
      if (free[v]) vfree = ($bits(vfree))'(v);
    vold = '0;
    for (int v = 1; v < NVOICE; v++)
      if (age[v] > age[vold]) vold = ($bits(vold))'(v);
    vsel      = any_free ? vfree : vold;
    hit       = '0;
    hit[vsel] = gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_d    <= '0;
      pending  <= '0;
      ptr      <= '0;
      trig_out <= '0;
      steal    <= 1'b0;
      src_q    <= '0;
    end else begin
      req_d    <= req;
      // Clear the granted bit first so a coincident edge re-arms it.
      pending  <= (pending & ~gmask) | edge_det;
      trig_out <= hit;
      steal    <= gnt & ~any_free;
      if (gnt) begin
        ptr         <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        src_q[vsel] <= gidx;
      end
    end
  end

  assign src_out = src_q;
endmodule

// File: tb/tb_voice_alloc.sv
// Scoreboard bench for voice_alloc: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the allocation rules.
module tb_voice_alloc;
  localparam int NR = 4, NV = 4, AGEW = 16;
  localparam int AGEMAX = (1 << AGEW) - 1;

  logic          clk = 0, rst, ena;
  logic [NR-1:0] req;
  logic [NV-1:0] busy, trig_out;
  logic [7:0]    src_out;
  logic          steal;

  voice_alloc #(.NREQ(NR), .NVOICE(NV), .AGEW(AGEW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .busy(busy),
    .trig_out(trig_out), .src_out(src_out), .steal(steal)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [3:0] trig; logic [7:0] src; logic stl; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  bit rst_seen = 0;

  // Behavioural model: rules evaluated once per rising edge.
  int m_age[NV], m_claim[NV], m_src[NV], m_ptr;
  bit m_pend[NR], m_reqd[NR];
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rst_seen = rst;
      if (rst) begin
        for (int i = 0; i < NV; i++) begin m_age[i] = 0; m_claim[i] = 0; m_src[i] = 0; end
        for (int i = 0; i < NR; i++) begin m_pend[i] = 0; m_reqd[i] = 0; end
        m_ptr = 0;
      end else begin
        int g, v;
        bit st;
        g = -1; v = -1; st = 0;
        if (ena)
          for (int k = 0; k < NR; k++)
            if (g < 0 && m_pend[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        if (g >= 0) begin
          for (int i = 0; i < NV; i++)
            if (v < 0 && !busy[i] && m_claim[i] == 0) v = i;
          if (v < 0) begin
            st = 1; v = 0;
            for (int i = 1; i < NV; i++) if (m_age[i] > m_age[v]) v = i;
          end
          m_pend[g] = 0;
          m_ptr = (g + 1) % NR;
        end
        if (ena)
          for (int i = 0; i < NV; i++) begin
            if (m_claim[i] > 0) m_claim[i]--;
            if (m_age[i] < AGEMAX) m_age[i]++;
          end
        if (g >= 0) begin
          exp_t e;
          m_claim[v] = 2; m_age[v] = 0; m_src[v] = g;
          e.cyc = cyc; e.trig = 4'(1 << v); e.stl = st; e.src = '0;
          for (int i = 0; i < NV; i++) e.src[2*i +: 2] = 2'(m_src[i]);
          q.push_back(e);
        end
        for (int i = 0; i < NR; i++) begin
          if (req[i] && !m_reqd[i]) m_pend[i] = 1;
          m_reqd[i] = req[i];
        end
      end
    end
  end

  // Monitor: outputs sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        checks++;
        if (trig_out !== '0 || steal !== 1'b0 || src_out !== '0) begin
          errors++;
          $display("FAIL reset_outputs cyc=%0d got trig=%b steal=%b src=%h want 0", cyc, trig_out, steal, src_out);
        end
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (trig_out !== e.trig || src_out !== e.src || steal !== e.stl) begin
          errors++;
          $display("FAIL grant cyc=%0d got trig=%b src=%h steal=%b want trig=%b src=%h steal=%b",
                   cyc, trig_out, src_out, steal, e.trig, e.src, e.stl);
        end
      end else if (trig_out !== '0 || steal !== 1'b0) begin
        checks++; errors++;
        $display("FAIL spurious cyc=%0d got trig=%b steal=%b want none", cyc, trig_out, steal);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] m);
    req = req | m;
    step(1);
    req = req & ~m;
  endtask

  initial begin
    rst = 1; ena = 1; req = '0; busy = '0;
    step(3);
    rst = 0;
    // single request on requester 2
    pulse(4'b0100); step(5);
    // three simultaneous edges, consecutive grants
    pulse(4'b1011); step(6);
    // fill the last voice, then steal by age
    busy = 4'b0111; pulse(4'b0001); step(3);
    busy = 4'b1111; step(30);
    pulse(4'b0010); step(10);
    pulse(4'b1000); step(4);
    // enable held low while a request rises
    busy = '0; step(4);
    ena = 0; req[0] = 1; step(5);
    ena = 1; step(3); req[0] = 0; step(2);
    // reset discards pending requests
    ena = 0; pulse(4'b0110); step(1);
    rst = 1; step(1);
    rst = 0; ena = 1; step(6);
    // repeat edge on one requester while busy lags
    req[1] = 1; step(1); req[1] = 0; step(1); req[1] = 1; step(1); req[1] = 0; step(6);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 199) == 0);
      ena  = ($urandom_range(0, 7) != 0);
      req  = req ^ 4'($urandom & $urandom);
      busy = ($urandom_range(0, 3) == 0) ? 4'($urandom) : busy;
      step(1);
    end
    rst = 0; ena = 1; req = '0;
    step(8);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding grants want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of trigger requesters (bitseq data_out lines).
REQ-002 The block SHALL have parameter NVOICE, default 4: number of envseq voices served.
REQ-003 The block SHALL have parameter AGEW, default 16: width of each voice age counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port ena, input, 1 bit: enable.
REQ-007 The block SHALL have port req, input, NREQ bits: level trigger lines; a 0->1 transition is one note request.
REQ-008 The block SHALL have port busy, input, NVOICE bits: voice v envelope active.
REQ-009 The block SHALL have port trig_out, output, NVOICE bits: one-cycle trigger pulse to voice v.
REQ-010 The block SHALL have port src_out, output, NVOICE*$clog2(NREQ) bits: requester index owning voice v, in slice v.
REQ-011 The block SHALL have port steal, output, 1 bit: one-cycle pulse, coincident with trig_out, when an active voice was reassigned.

Function
REQ-012 Edge detect: req SHALL be registered into req_d every cycle regardless of ena; edge[i] = req[i] & ~req_d[i].
REQ-013 Pending: edge[i] SHALL set pending[i] at the next clock edge; a new edge on an already-pending requester SHALL merge (no second grant).
REQ-014 Grant: when ena=1 and any pending bit is set, exactly one requester SHALL be granted per cycle; others stay pending.
REQ-015 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod NREQ; after reset the pointer SHALL make requester 0 highest priority.
REQ-016 A voice SHALL be free when busy[v]=0 and its claim counter is 0; the granted request SHALL go to the lowest-index free voice.
REQ-017 If no voice is free, the request SHALL go to the voice with the largest age, lowest index on ties, and steal SHALL pulse.
REQ-018 On grant, trig_out[v] SHALL be 1 for exactly the following cycle (registered output), and src_out slice v SHALL load the granted index in the same edge.
REQ-019 Latency: req high at clock edge k sets pending at k; trig_out SHALL be high during cycle k+1 to k+2 when uncontended and ena=1.
REQ-020 The granted pending bit SHALL clear at the grant edge; an edge arriving on that requester at the same edge SHALL leave it pending.
REQ-021 Claim: on trigger, the claim counter of voice v SHALL load 2 and decrement by one each cycle to 0, masking envseq busy-reporting latency.
REQ-022 Age: age[v] SHALL clear to 0 at trigger and increment by one each ena=1 cycle, saturating at 2^AGEW-1 (no wrap).
REQ-023 ena=0 SHALL suppress grants, freeze ages and round-robin pointer, hold claim counters, and retain pending bits; edges SHALL still be captured.
REQ-024 At most one trig_out bit SHALL be high in any cycle.

Reset
REQ-025 While rst=1, at each edge: trig_out=0, steal=0, src_out=0, pending=0, req_d=0, ages=0, claims=0, and the round-robin pointer is set so that requester 0 has priority; rst SHALL override all other inputs, and rst asserted mid-operation SHALL discard pending requests.
REQ-026 On the first cycle after reset release, a req already high SHALL count as an edge (req_d=0).

Verification
REQ-027 The bench SHALL cover: NREQ=NVOICE=4, busy=0, single pulse on req[2] -> trig_out=4'b0001 exactly two cycles later, src_out slice0=2, steal=0.
REQ-028 The bench SHALL cover: req=4'b1011 rising together -> grants on consecutive cycles in order 0,1,3 to voices 0,1,2, three single-cycle pulses.
REQ-029 The bench SHALL cover: busy=4'b1111, ages 10/40/40/5 -> next request goes to voice 1, steal=1, age[1] cleared.
REQ-030 The bench SHALL cover: ena=0 while req[0] rises, held 5 cycles -> no trig_out; ena back to 1 -> trig_out one cycle after ena returns to 1.
REQ-031 The bench SHALL cover: rst for one cycle while pending=4'b0110 -> all outputs 0, no grant after release unless a new edge occurs.
REQ-032 The bench SHALL cover: second req[1] edge one cycle after first, with busy slow -> voice 0 then voice 1 (claim mask), never voice 0 twice.
